// File: rtl/square_floor_checker_pkg.sv
// Shared widths and FSM encoding for the square-root family of blocks.
package square_floor_checker_pkg;
    localparam int ROOT_W = 5;
    localparam int NUM_W  = 2 * ROOT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sq_state_t;
endpackage

// File: rtl/square_floor_checker_shift_add_squarer.sv
// Sequential squarer: one shift-add partial product per step, LSB of root first.
module shift_add_squarer
    import square_floor_checker_pkg::*;
#(
    parameter int ROOT_W = square_floor_checker_pkg::ROOT_W,
    parameter int NUM_W  = square_floor_checker_pkg::NUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ROOT_W-1:0] root,
    output logic [NUM_W-1:0]  acc,
    output logic              last
);
    localparam int CNT_W = $clog2(ROOT_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [NUM_W-1:0]  mcand;
    logic [ROOT_W-1:0] mbits;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            mcand <= '0;
            mbits <= '0;
        end else if (load) begin
            acc   <= '0;
            cnt   <= CNT_W'(ROOT_W);
            mcand <= {{(NUM_W-ROOT_W){1'b0}}, root};
            mbits <= root;
        end else if (step && cnt != '0) begin
            // mcand tracks root << bit_index; mbits[0] is the current root bit
            if (mbits[0])
                acc <= acc + mcand;
            mcand <= mcand << 1;
            mbits <= mbits >> 1;
            cnt   <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/square_floor_checker.sv
// Checks whether root is the floor square root of num; reports square and remainder.
module square_floor_checker
    import square_floor_checker_pkg::*;
#(
    parameter int ROOT_W = square_floor_checker_pkg::ROOT_W,
    parameter int NUM_W  = square_floor_checker_pkg::NUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROOT_W-1:0] root,
    input  logic [NUM_W-1:0]  num,
    output logic              busy,
    output logic              done,
    output logic [NUM_W-1:0]  square,
    output logic [NUM_W-1:0]  remainder,
    output logic              is_floor
);
    sq_state_t         state;
    logic [ROOT_W-1:0] root_q;
    logic [NUM_W-1:0]  num_q;
    logic [NUM_W-1:0]  acc;
    logic              last;
    logic              load;
    logic              step;
    logic [NUM_W:0]    next_sq;
    logic              sq_le;
    logic              floor_c;
    logic [NUM_W-1:0]  rem_c;

    assign load = (state == IDLE) && start;
    assign step = (state == CALC);

    shift_add_squarer #(
        .ROOT_W(ROOT_W),
        .NUM_W (NUM_W)
    ) u_squarer (
        .clk (clk),
        .rst (rst),
        .load(load),
        .step(step),
        .root(root),
        .acc (acc),
        .last(last)
    );

    // (root+1)^2 = root^2 + 2*root + 1; one extra bit covers (2^ROOT_W)^2
    always_comb begin
        next_sq = {1'b0, acc} + {{(NUM_W-ROOT_W){1'b0}}, root_q, 1'b0} + (NUM_W+1)'(1);
        sq_le   = (acc <= num_q);
        floor_c = sq_le && ({1'b0, num_q} < next_sq);
        rem_c   = sq_le ? (num_q - acc) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            root_q    <= '0;
            num_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            square    <= '0;
            remainder <= '0;
            is_floor  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        root_q <= root;
                        num_q  <= num;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (last)
                        state <= CHECK;
                end
                CHECK: begin
                    square    <= acc;
                    remainder <= rem_c;
                    is_floor  <= floor_c;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_square_floor_checker.sv
// Directed vector bench for square_floor_checker.
module tb_square_floor_checker;
    localparam int ROOT_W = 5;
    localparam int NUM_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROOT_W-1:0] root;
    logic [NUM_W-1:0]  num;
    logic              busy;
    logic              done;
    logic [NUM_W-1:0]  square;
    logic [NUM_W-1:0]  remainder;
    logic              is_floor;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int root;
        int num;
        int sq;
        int rem;
        int fl;
    } vec_t;

    vec_t vecs[11];

    square_floor_checker #(.ROOT_W(ROOT_W), .NUM_W(NUM_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .root     (root),
        .num      (num),
        .busy     (busy),
        .done     (done),
        .square   (square),
        .remainder(remainder),
        .is_floor (is_floor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Call at a negedge in an IDLE cycle; returns at the negedge following the done cycle.
    // Operands are scrambled after capture, so results must come from the captured values.
    task automatic run_op(input string tag, input int r, input int n,
                          input int e_sq, input int e_rem, input int e_fl);
        int cyc;
        start = 1'b1;
        root  = ROOT_W'(r);
        num   = NUM_W'(n);
        @(negedge clk);
        start = 1'b0;
        root  = ~root;
        num   = ~num;
        cyc   = 1;
        chk({tag, " busy"}, int'(busy), 1);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_cycle"}, cyc, 7);
        chk({tag, " square"}, int'(square), e_sq);
        chk({tag, " remainder"}, int'(remainder), e_rem);
        chk({tag, " is_floor"}, int'(is_floor), e_fl);
        @(negedge clk);
        chk({tag, " done_pulse"}, int'(done), 0);
        chk({tag, " hold_square"}, int'(square), e_sq);
    endtask

    initial begin
        vecs[0]  = '{4, 19, 16, 3, 1};
        vecs[1]  = '{5, 19, 25, 0, 0};
        vecs[2]  = '{31, 1023, 961, 62, 1};
        vecs[3]  = '{31, 960, 961, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1};
        vecs[5]  = '{0, 1, 0, 1, 0};
        vecs[6]  = '{3, 15, 9, 6, 1};
        vecs[7]  = '{3, 16, 9, 7, 0};
        vecs[8]  = '{1, 3, 1, 2, 1};
        vecs[9]  = '{10, 120, 100, 20, 1};
        vecs[10] = '{10, 121, 100, 21, 0};

        rst = 1'b1; start = 1'b0; root = '0; num = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset square", int'(square), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset is_floor", int'(is_floor), 0);

        // Start on the first edge after reset deasserts; table runs back-to-back.
        rst = 1'b0;
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].root, vecs[i].num,
                   vecs[i].sq, vecs[i].rem, vecs[i].fl);

        // Start pulsed mid-operation with other operands must be ignored.
        begin
            int cyc;
            start = 1'b1; root = 5'd4; num = 10'd19;
            @(negedge clk);
            start = 1'b0; cyc = 1;
            repeat (2) @(negedge clk);
            cyc = 3;
            start = 1'b1; root = 5'd31; num = 10'd0;
            @(negedge clk);
            start = 1'b0; cyc = 4;
            while (!done && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("ignore done_cycle", cyc, 7);
            chk("ignore square", int'(square), 16);
            chk("ignore remainder", int'(remainder), 3);
            chk("ignore is_floor", int'(is_floor), 1);
            @(negedge clk);
            run_op("after_ignore", 5, 30, 25, 5, 1);
        end

        // Reset mid-operation aborts with no done pulse and zeroed outputs.
        begin
            int seen;
            start = 1'b1; root = 5'd6; num = 10'd40;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort busy", int'(busy), 0);
            chk("abort done", int'(done), 0);
            chk("abort square", int'(square), 0);
            chk("abort remainder", int'(remainder), 0);
            chk("abort is_floor", int'(is_floor), 0);
            rst = 1'b0;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("abort no_done", seen, 0);
            run_op("after_abort", 6, 40, 36, 4, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/square_floor_checker.md
SQUARE_FLOOR_CHECKER -- requirements
Module: square_floor_checker

Interface
REQ-001 SHALL have parameter ROOT_W, default 5, root operand width.
REQ-002 SHALL have parameter NUM_W, default 10 (2*ROOT_W), number operand and square width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port root  input  ROOT_W  candidate floor square root, captured on accepted start.
REQ-007 SHALL have port num  input  NUM_W  number under test, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port square  output  NUM_W  root*root.
REQ-011 SHALL have port remainder  output  NUM_W  num - root*root when root*root <= num, else 0.
REQ-012 SHALL have port is_floor  output  1  high iff root*root <= num < (root+1)*(root+1).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, CHECK, DONE.
REQ-014 SHALL, in IDLE with start=1 (cycle 0), capture root and num, clear the accumulator, load a bit counter with ROOT_W, and go to CALC.
REQ-015 SHALL, in CALC, perform one shift-add step per cycle: if the current root bit (LSB first) is 1, add root shifted left by the bit index to the accumulator; stay exactly ROOT_W cycles (cycles 1..5 at default).
REQ-016 SHALL, in CHECK (cycle ROOT_W+1), compute next_sq = acc + 2*root + 1 at NUM_W+1 bits (32*32=1024 requires 11 bits), then evaluate is_floor and remainder and register them with square.
REQ-017 SHALL, in DONE (cycle ROOT_W+2), assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL keep the accumulator NUM_W bits wide without overflow; (2^ROOT_W-1)^2 = 961 fits in 10 bits.
REQ-019 SHALL hold square, remainder and is_floor stable from DONE until the next accepted start updates them in CHECK.
REQ-020 SHALL ignore start while busy=1, with no effect on captured operands or timing.
REQ-021 SHALL accept start in the IDLE cycle that immediately follows DONE (back-to-back throughput of one result per ROOT_W+3 cycles).
REQ-022 SHALL ignore root and num changes after capture.
REQ-023 SHALL, for root=0, produce square=0 and is_floor = (num==0).

Reset
REQ-024 SHALL, while rst=1 at a clock edge, force state to IDLE, busy=0, done=0, square=0, remainder=0, is_floor=0, and clear the counter and accumulator.
REQ-025 SHALL let rst take priority over start and abort any operation in progress with no done pulse.
REQ-026 SHALL accept start on the first edge after rst deasserts.

Structure
REQ-027 SHALL place ROOT_W, NUM_W and the FSM state encodings in a shared package/header used by both square_floor_checker and the existing square-root block.
REQ-028 SHALL contain one sub-module, shift_add_squarer (accumulator, counter, shift-add step), with FSM and compare logic in the top level.
REQ-029 SHALL have registered outputs only, with no combinational path from inputs to outputs.

Verification
REQ-030 SHALL cover: root=4, num=19, start pulse -> done at cycle 7; square=16, remainder=3, is_floor=1.
REQ-031 SHALL cover: root=5, num=19 -> square=25, remainder=0, is_floor=0.
REQ-032 SHALL cover: root=31, num=1023 -> square=961, remainder=62, is_floor=1 (11-bit next_sq=1024 boundary); root=31, num=960 -> is_floor=0.
REQ-033 SHALL cover: root=0, num=0 -> square=0, is_floor=1; root=0, num=1 -> is_floor=0, remainder=1.
REQ-034 SHALL cover: start pulsed at cycle 3 of an operation with different operands -> ignored; original result reported at cycle 7; a new start at cycle 8 is accepted.
REQ-035 SHALL cover: rst asserted at cycle 4 of an operation -> no done pulse; all outputs are 0 on the next cycle; a fresh start afterwards completes normally.
